// File: rtl/morph_pkg.sv
// morph_pkg: shared FSM state encoding and kernel indices for the morphology kernel bank
package morph_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PEND_SWAP} state_t;
    localparam int KID_OP_ERO  = 0;
    localparam int KID_OP_DILA = 1;
    localparam int KID_CL_ERO  = 2;
    localparam int KID_CL_DILA = 3;
endpackage

// File: rtl/kernel_bank.sv
// kernel_bank: one bank of NK kernels x KW signed taps, one write port, NK combinational read ports
module kernel_bank #(
    parameter int KW = 71,
    parameter int DW = 8,
    parameter int NK = 4,
    localparam int AW = $clog2(KW),
    localparam int IW = $clog2(NK * KW)
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  we,
    input  logic [IW-1:0]         widx,
    input  logic signed [DW-1:0]  wdata,
    input  logic [NK-1:0][AW-1:0] raddr,
    output logic [NK-1:0][DW-1:0] rdata
);
    logic signed [DW-1:0] mem [NK*KW];

    // tap storage; reset gives a flat (all-zero) structuring element
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NK * KW; i++) mem[i] <= '0;
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    for (genvar k = 0; k < NK; k++) begin : g_rd
        localparam logic [IW-1:0] BASE = IW'(k * KW);
        logic [IW-1:0] ridx;
        assign ridx     = BASE + IW'(raddr[k]);
        assign rdata[k] = (int'(raddr[k]) < KW) ? mem[ridx] : '0;
    end
endmodule

// File: rtl/kernel_bank_ctrl.sv
// kernel_bank_ctrl: double-buffered kernel LUTs loaded over a stream, swapped when the filter is idle
module kernel_bank_ctrl
    import morph_pkg::*;
#(
    parameter int KERNEL_WIDTH      = 71,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int NUM_KERNELS       = 4,
    localparam int AW = $clog2(KERNEL_WIDTH)
) (
    input  logic                                clk,
    input  logic                                areset_n,
    input  logic signed [KERNEL_DATA_WIDTH-1:0] cfg_tdata,
    input  logic                                cfg_tvalid,
    output logic                                cfg_tready,
    input  logic                                cfg_tlast,
    input  logic                                swap_allowed,
    input  logic [AW-1:0]                       op_ero_kernel_lut_address,
    input  logic [AW-1:0]                       op_dila_kernel_lut_address,
    input  logic [AW-1:0]                       cl_ero_kernel_lut_address,
    input  logic [AW-1:0]                       cl_dila_kernel_lut_address,
    output logic signed [KERNEL_DATA_WIDTH-1:0] op_ero_kernel_lut_data,
    output logic signed [KERNEL_DATA_WIDTH-1:0] op_dila_kernel_lut_data,
    output logic signed [KERNEL_DATA_WIDTH-1:0] cl_ero_kernel_lut_data,
    output logic signed [KERNEL_DATA_WIDTH-1:0] cl_dila_kernel_lut_data,
    output logic                                kernel_valid,
    output logic                                busy,
    output logic                                swap_done,
    output logic                                load_error
);
    localparam int TOTAL = NUM_KERNELS * KERNEL_WIDTH;
    localparam int IW    = $clog2(TOTAL);
    localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);

    state_t state, state_nxt;
    logic [IW-1:0] cnt, cnt_nxt, wr_idx;
    logic bank_sel, wr_en, err_nxt, swap_nxt;
    logic [NUM_KERNELS-1:0][AW-1:0] raddr;
    logic [NUM_KERNELS-1:0][KERNEL_DATA_WIDTH-1:0] rd0, rd1, rd;

    assign cfg_tready = (state != PEND_SWAP);
    assign busy       = (state != IDLE);

    // next-state, shadow write and framing-error decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_idx    = cnt;
        err_nxt   = 1'b0;
        swap_nxt  = 1'b0;
        case (state)
            IDLE: if (cfg_tvalid) begin
                wr_en  = 1'b1;
                wr_idx = '0;
                if (cfg_tlast) err_nxt = 1'b1;
                else begin
                    state_nxt = LOAD;
                    cnt_nxt   = IW'(1);
                end
            end
            LOAD: if (cfg_tvalid) begin
                wr_en = 1'b1;
                if (cnt == LAST) begin
                    err_nxt   = !cfg_tlast;
                    state_nxt = cfg_tlast ? PEND_SWAP : DRAIN;
                    cnt_nxt   = '0;
                end else if (cfg_tlast) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRAIN: if (cfg_tvalid && cfg_tlast) state_nxt = IDLE;
            PEND_SWAP: if (swap_allowed) begin
                swap_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, beat counter, active-bank select and status pulses
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bank_sel     <= 1'b0;
            kernel_valid <= 1'b0;
            swap_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            swap_done  <= swap_nxt;
            load_error <= err_nxt;
            if (swap_nxt) begin
                bank_sel     <= ~bank_sel;
                kernel_valid <= 1'b1;
            end
        end
    end

    assign raddr[KID_OP_ERO]  = op_ero_kernel_lut_address;
    assign raddr[KID_OP_DILA] = op_dila_kernel_lut_address;
    assign raddr[KID_CL_ERO]  = cl_ero_kernel_lut_address;
    assign raddr[KID_CL_DILA] = cl_dila_kernel_lut_address;

    kernel_bank #(.KW(KERNEL_WIDTH), .DW(KERNEL_DATA_WIDTH), .NK(NUM_KERNELS)) u_bank0 (
        .clk(clk), .areset_n(areset_n), .we(wr_en && bank_sel), .widx(wr_idx),
        .wdata(cfg_tdata), .raddr(raddr), .rdata(rd0)
    );

    kernel_bank #(.KW(KERNEL_WIDTH), .DW(KERNEL_DATA_WIDTH), .NK(NUM_KERNELS)) u_bank1 (
        .clk(clk), .areset_n(areset_n), .we(wr_en && !bank_sel), .widx(wr_idx),
        .wdata(cfg_tdata), .raddr(raddr), .rdata(rd1)
    );

    assign rd = bank_sel ? rd1 : rd0;
    assign op_ero_kernel_lut_data  = rd[KID_OP_ERO];
    assign op_dila_kernel_lut_data = rd[KID_OP_DILA];
    assign cl_ero_kernel_lut_data  = rd[KID_CL_ERO];
    assign cl_dila_kernel_lut_data = rd[KID_CL_DILA];
endmodule
